count_stim_driver: RTL and testbench
====================================

# count_stim_driver

Transmit-side companion to the team's dual-channel event counter: it generates the `En`/`Slt` strobe stream that counter consumes. Given two programmed targets, it emits `Target0` channel-0 strobes, then `Target1` groups of `GROUP` channel-1 strobes. The receiving counter therefore ends at `Output0 += Target0` and `Output1 += Target1`. It sits between the test/control logic and the counter, optionally spacing strobes with idle gap cycles.

## Interface
- `CNT_W`, 16, width of targets and sent counters.
- `GROUP`, 4, channel-1 strobes per channel-1 event; must be ≥1 and must equal the receiver's group size.
- `GAP`, 0, idle cycles (`En`=0) inserted after every strobe.
- `Clk`  in  1  single clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high; overrides every other input.
- `Start`  in  1  start request; sampled only in IDLE.
- `Abort`  in  1  terminate the current run; sampled only while busy.
- `Target0`  in  `CNT_W`  channel-0 strobe count; latched on accepted `Start`.
- `Target1`  in  `CNT_W`  channel-1 event count; latched on accepted `Start`.
- `En`  out  1  strobe-valid to the counter; registered.
- `Slt`  out  1  channel select (0 = ch0, 1 = ch1); registered; forced to 0 whenever `En`=0.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse on normal completion.
- `Sent0`  out  `CNT_W`  ch0 strobes issued in current/last run.
- `Sent1`  out  `CNT_W`  ch1 events completed in current/last run.

## Operation
- Reset values: `En`=0, `Slt`=0, `Busy`=0, `Done`=0, `Sent0`=0, `Sent1`=0, state IDLE, latched targets 0, group sub-counter 0.
- States:
  - **IDLE**
    - Outputs: `En`/`Slt`/`Busy` low.
    - On `Start`: latch targets, clear `Sent0`/`Sent1` and the sub-counter.
    - Next state: PULSE0 if `Target0`≠0, else PULSE1 if `Target1`≠0, else FIN.
  - **PULSE0**
    - Outputs: `En`=1, `Slt`=0 for exactly one cycle.
    - `Sent0` increments at the end of the cycle.
    - Next state: GAP if `GAP`>0. Otherwise, PULSE0 again while `Sent0`+1 < `Target0`, then PULSE1 or FIN.
  - **PULSE1**
    - Outputs: `En`=1, `Slt`=1 for one cycle.
    - The sub-counter increments. When it reaches `GROUP`, it clears and `Sent1` increments.
    - Continue until `Sent1` = `Target1`, then FIN.
  - **GAP**
    - Outputs: `En`=0, `Slt`=0 for exactly `GAP` cycles.
    - A return-channel flag selects the next state using the same rules as above.
  - **FIN**
    - Outputs: `Done`=1 and `Busy`=1 for one cycle, `En`=0.
    - Next state: IDLE.
- `Start` while `Busy`: ignored; latched targets do not change.
- `Abort` while `Busy`, in any state including FIN:
  - Next state IDLE; `En`/`Slt` low from the next cycle.
  - No `Done`; `Sent0`/`Sent1` retain their values.
  - A partially sent group is not counted in `Sent1`.
- `Abort` in IDLE: ignored. `Start`+`Abort` together in IDLE: `Start` accepted.
- `Reset` mid-run: all outputs return to reset values on the next edge; a `Start` in the same cycle as `Reset` is dropped.
- Arithmetic:
  - `Sent` counters are bounded by the targets and never wrap.
  - Max `Target` is 2^`CNT_W`−1.
  - Sub-counter width is clog2(`GROUP`+1).
  - Total strobes per run = `Target0` + `GROUP`·`Target1`.

## Timing
- `Start` sampled at edge t → first strobe (`En`=1) in the cycle following edge t. This is one cycle of latency.
- Run length in cycles, where N = `Target0` + `GROUP`·`Target1`:
  - Strobe and gap cycles: N·(1+`GAP`).
  - `Done` asserts in the cycle immediately after the last strobe or gap cycle.
  - Both targets 0: `Done` asserts in the cycle after `Start`.
- With `GAP`=0, strobes are back-to-back with no idle cycle at the ch0→ch1 switch.
- The earliest next `Start` is accepted in the cycle after FIN (state IDLE).
- Outputs are Moore/registered; no combinational path from any input to `En`/`Slt`.

## Structure
- Shared include/package holds:
  - the state encodings (IDLE, PULSE0, PULSE1, GAP, FIN);
  - default `CNT_W`/`GROUP`/`GAP`;
  - the `Slt` channel constants. The receiving counter uses these same constants.
- One natural sub-module, `stim_gap_timer`:
  - loadable down-counter of width clog2(`GAP`+1);
  - `load`/`expired` interface;
  - instantiated only when `GAP`>0.

## Test plan
- `GAP`=0, `Target0`=3, `Target1`=0, `Start` at edge 0 → `En`=1/`Slt`=0 in cycles 1–3; `Done` in cycle 4; `Sent0`=3; `Busy` low from cycle 5.
- `Target0`=2, `Target1`=2, `GROUP`=4 → 2 strobes with `Slt`=0, then 8 with `Slt`=1; `Done` in cycle 11; `Sent1`=2; attached counter model shows `Output0`=2, `Output1`=2.
- `GAP`=2, `Target0`=2 → `En` pattern 1,0,0,1,0,0 over cycles 1–6; `Done` in cycle 7.
- Both targets 0 → `Done` in cycle 1; `En` never asserted; `Sent0`=`Sent1`=0.
- `Target1`=3, `Abort` after the 5th `Slt` strobe → `En` low next cycle; no `Done`; `Sent1`=1; `Busy`=0. A `Start` issued mid-run is ignored, and the latched targets are unchanged.
- `Reset` asserted mid-PULSE1, with `Start` high in the same cycle → all outputs 0 next cycle; state IDLE; no run begins.

Source files
------------

// File: rtl/count_stim_driver_pkg.sv
// Shared constants for the strobe driver and its receiving counter:
// state encodings, default sizing and the Slt channel codes.
package count_stim_driver_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_GROUP = 4;
    localparam int DEF_GAP   = 0;

    localparam logic SLT_CH0 = 1'b0;
    localparam logic SLT_CH1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PULSE0 = 3'd1,
        ST_PULSE1 = 3'd2,
        ST_GAP    = 3'd3,
        ST_FIN    = 3'd4
    } stim_state_e;

endpackage

// File: rtl/count_stim_driver_if.sv
// Control/status bundle between the test logic (master) and the strobe driver (slave).
interface count_stim_driver_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] target0;
    logic [CNT_W-1:0] target1;
    logic             en;
    logic             slt;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent0;
    logic [CNT_W-1:0] sent1;

    modport master (
        output start, abort, target0, target1,
        input  en, slt, busy, done, sent0, sent1
    );

    modport slave (
        input  start, abort, target0, target1,
        output en, slt, busy, done, sent0, sent1
    );
endinterface

// File: rtl/count_stim_driver_gap_timer.sv
// Idle-gap down-counter: reloads on every strobe and reports expiry
// on the last idle cycle of the gap.
module stim_gap_timer #(
    parameter int GAP = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    output logic o_expired
);
    localparam int             W        = $clog2(GAP + 1);
    localparam logic [W-1:0]   LOAD_VAL = W'(GAP - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/count_stim_driver.sv
// Generates the En/Slt strobe stream for the dual-channel event counter:
// Target0 ch0 strobes, then Target1 groups of GROUP ch1 strobes.
//
// state  | meaning
// IDLE   | waiting for Start, outputs quiet
// PULSE0 | one ch0 strobe
// PULSE1 | one ch1 strobe (part of a group)
// GAP    | GAP idle cycles after a strobe
// FIN    | one-cycle Done pulse
module count_stim_driver
    import count_stim_driver_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int GROUP = DEF_GROUP,
    parameter int GAP   = DEF_GAP
) (
    input  logic               i_clk,
    input  logic               i_reset,
    count_stim_driver_if.slave bus
);
    localparam int               SUB_W    = $clog2(GROUP + 1);
    localparam int               CW1      = CNT_W + 1;
    localparam logic [SUB_W-1:0] GRP_LAST = SUB_W'(GROUP - 1);

    stim_state_e      r_state;
    stim_state_e      w_next;
    logic [CNT_W-1:0] r_tgt0, r_tgt1, r_sent0, r_sent1;
    logic [SUB_W-1:0] r_sub;
    logic             r_ret_ch;
    logic             w_busy, w_en, w_slt, w_done;
    logic             w_last0, w_grp_end, w_last1, w_gap_expired;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_last0   = (CW1'(r_sent0) + CW1'(1)) >= CW1'(r_tgt0);
    assign w_grp_end = (r_sub == GRP_LAST);
    assign w_last1   = w_grp_end && ((CW1'(r_sent1) + CW1'(1)) >= CW1'(r_tgt1));

    generate
        if (GAP > 0) begin : g_gap
            stim_gap_timer #(.GAP(GAP)) u_gap_timer (
                .i_clk     (i_clk),
                .i_reset   (i_reset),
                .i_load    (w_en),
                .o_expired (w_gap_expired)
            );
        end else begin : g_no_gap
            assign w_gap_expired = 1'b1;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.target0 != '0)      w_next = ST_PULSE0;
                    else if (bus.target1 != '0) w_next = ST_PULSE1;
                    else                        w_next = ST_FIN;
                end
            end
            ST_PULSE0: begin
                if (GAP > 0)             w_next = ST_GAP;
                else if (!w_last0)       w_next = ST_PULSE0;
                else if (r_tgt1 != '0)   w_next = ST_PULSE1;
                else                     w_next = ST_FIN;
            end
            ST_PULSE1: begin
                if (GAP > 0)       w_next = ST_GAP;
                else if (w_last1)  w_next = ST_FIN;
                else               w_next = ST_PULSE1;
            end
            ST_GAP: begin
                // counters were already updated by the strobe that opened this gap
                if (w_gap_expired) begin
                    if (r_ret_ch == SLT_CH0) begin
                        if (r_sent0 != r_tgt0)    w_next = ST_PULSE0;
                        else if (r_tgt1 != '0)    w_next = ST_PULSE1;
                        else                      w_next = ST_FIN;
                    end else begin
                        if (r_sent1 != r_tgt1)    w_next = ST_PULSE1;
                        else                      w_next = ST_FIN;
                    end
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (w_busy && bus.abort) begin
            w_next = ST_IDLE;
        end
    end

    always_comb begin
        w_en   = 1'b0;
        w_slt  = SLT_CH0;
        w_done = 1'b0;
        case (r_state)
            ST_PULSE0: w_en = 1'b1;
            ST_PULSE1: begin
                w_en  = 1'b1;
                w_slt = SLT_CH1;
            end
            ST_FIN:    w_done = 1'b1;
            default: ;
        endcase
    end

    // Abort freezes the counters, so a half-sent group never reaches Sent1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tgt0   <= '0;
            r_tgt1   <= '0;
            r_sent0  <= '0;
            r_sent1  <= '0;
            r_sub    <= '0;
            r_ret_ch <= SLT_CH0;
        end else if (r_state == ST_IDLE) begin
            if (bus.start) begin
                r_tgt0  <= bus.target0;
                r_tgt1  <= bus.target1;
                r_sent0 <= '0;
                r_sent1 <= '0;
                r_sub   <= '0;
            end
        end else if (!bus.abort) begin
            if (r_state == ST_PULSE0) begin
                r_sent0  <= r_sent0 + 1'b1;
                r_ret_ch <= SLT_CH0;
            end
            if (r_state == ST_PULSE1) begin
                r_ret_ch <= SLT_CH1;
                if (w_grp_end) begin
                    r_sub   <= '0;
                    r_sent1 <= r_sent1 + 1'b1;
                end else begin
                    r_sub <= r_sub + 1'b1;
                end
            end
        end
    end

    assign bus.en    = w_en;
    assign bus.slt   = w_slt;
    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.sent0 = r_sent0;
    assign bus.sent1 = r_sent1;

endmodule

// File: tb/tb_count_stim_driver.sv
// Bench for count_stim_driver: a GAP=0 and a GAP=2 instance checked against
// an expected per-cycle En/Slt/Done/Busy trace built from the target counts.
module tb_count_stim_driver;
    import count_stim_driver_pkg::*;

    localparam int CW  = DEF_CNT_W;
    localparam int GRP = DEF_GROUP;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    count_stim_driver_if #(.CNT_W(CW)) bus0 ();
    count_stim_driver_if #(.CNT_W(CW)) bus2 ();

    count_stim_driver #(.CNT_W(CW), .GROUP(GRP), .GAP(0)) dut0 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus0.slave)
    );

    count_stim_driver #(.CNT_W(CW), .GROUP(GRP), .GAP(2)) dut2 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus2.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit sel;
        int t0;
        int t1;
        int done_cyc;
        int sent0;
        int sent1;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit sel, input bit st, input bit ab, input int t0, input int t1);
        if (sel) begin
            bus2.start = st; bus2.abort = ab;
            bus2.target0 = CW'(t0); bus2.target1 = CW'(t1);
        end else begin
            bus0.start = st; bus0.abort = ab;
            bus0.target0 = CW'(t0); bus0.target1 = CW'(t1);
        end
    endtask

    function automatic logic [3:0] obs(input bit sel);
        return sel ? {bus2.en, bus2.slt, bus2.done, bus2.busy}
                   : {bus0.en, bus0.slt, bus0.done, bus0.busy};
    endfunction

    function automatic int sent0_of(input bit sel);
        return sel ? int'(bus2.sent0) : int'(bus0.sent0);
    endfunction

    function automatic int sent1_of(input bit sel);
        return sel ? int'(bus2.sent1) : int'(bus0.sent1);
    endfunction

    // One complete run; the expected trace is every strobe followed by its gap,
    // then FIN, then IDLE. Returns observed Done cycle and strobe counts.
    task automatic run(input bit sel, input int t0, input int t1, input string tag,
                       output int done_cyc, output int n0, output int n1);
        logic [3:0] exp_q[$];
        logic [3:0] o;
        int gap = sel ? 2 : 0;
        bit bad = 1'b0;
        for (int i = 0; i < t0; i++) begin
            exp_q.push_back(4'b1001);
            repeat (gap) exp_q.push_back(4'b0001);
        end
        for (int i = 0; i < t1 * GRP; i++) begin
            exp_q.push_back(4'b1101);
            repeat (gap) exp_q.push_back(4'b0001);
        end
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0000);
        set_in(sel, 1'b1, 1'b0, t0, t1);
        tick();
        set_in(sel, 1'b0, 1'b0, t0, t1);
        done_cyc = -1; n0 = 0; n1 = 0;
        for (int cyc = 1; cyc <= exp_q.size(); cyc++) begin
            o = obs(sel);
            if (o[3]) begin
                if (o[2]) n1++;
                else      n0++;
            end
            if (o[1] && done_cyc < 0) done_cyc = cyc;
            if (o !== exp_q[cyc-1] && !bad) begin
                bad = 1'b1;
                $display("FAIL %s_trace cycle=%0d actual=%b required=%b", tag, cyc, o, exp_q[cyc-1]);
            end
            if (cyc < exp_q.size()) tick();
        end
        checks++;
        if (bad) failures++;
    endtask

    initial begin
        vec_t tbl[7];
        int dc, n0, n1, t0, t1;
        bit sel, seen;
        logic [3:0] o;

        tbl = '{
            '{1'b0, 3, 0,  4, 3, 0},
            '{1'b0, 2, 2, 11, 2, 2},
            '{1'b0, 0, 0,  1, 0, 0},
            '{1'b0, 0, 1,  5, 0, 1},
            '{1'b0, 1, 0,  2, 1, 0},
            '{1'b1, 2, 0,  7, 2, 0},
            '{1'b1, 1, 1, 16, 1, 1}
        };

        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 0, 0);
        set_in(1'b1, 1'b0, 1'b0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        check("reset_outs0", obs(1'b0), 0);
        check("reset_outs2", obs(1'b1), 0);
        check("reset_sent0", sent0_of(1'b0), 0);
        check("reset_sent1", sent1_of(1'b0), 0);

        foreach (tbl[k]) begin
            run(tbl[k].sel, tbl[k].t0, tbl[k].t1, "vec", dc, n0, n1);
            check("vec_done_cycle", dc, tbl[k].done_cyc);
            check("vec_sent0", sent0_of(tbl[k].sel), tbl[k].sent0);
            check("vec_sent1", sent1_of(tbl[k].sel), tbl[k].sent1);
            check("vec_rx_out0", n0, tbl[k].t0);
            check("vec_rx_out1", n1 / GRP, tbl[k].t1);
        end

        for (int r = 0; r < 16; r++) begin
            sel = 1'($urandom_range(0, 1));
            t0  = int'($urandom_range(0, 5));
            t1  = int'($urandom_range(0, 4));
            run(sel, t0, t1, "rand", dc, n0, n1);
            check("rand_sent0", sent0_of(sel), t0);
            check("rand_sent1", sent1_of(sel), t1);
            check("rand_strobes", n0 + n1, t0 + GRP * t1);
        end

        // Start and Abort together in IDLE: the Start wins.
        set_in(1'b0, 1'b1, 1'b1, 1, 0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1, 0);
        check("start_abort_en", obs(1'b0), 4'b1001);
        repeat (2) tick();
        check("start_abort_sent0", sent0_of(1'b0), 1);
        check("start_abort_idle", obs(1'b0), 0);

        // Start mid-run with new targets is ignored.
        set_in(1'b0, 1'b1, 1'b0, 2, 1);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 5, 3);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 5, 3);
        dc = -1;
        for (int cyc = 2; cyc <= 30 && dc < 0; cyc++) begin
            if (bus0.done) dc = cyc;
            else tick();
        end
        check("midstart_done_cycle", dc, 7);
        check("midstart_sent0", sent0_of(1'b0), 2);
        check("midstart_sent1", sent1_of(1'b0), 1);
        tick();

        // Abort right after the 5th ch1 strobe.
        set_in(1'b0, 1'b1, 1'b0, 0, 3);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 0, 3);
        n1 = 0; seen = 1'b0;
        for (int cyc = 1; cyc <= 20 && n1 < 5; cyc++) begin
            if (bus0.en && bus0.slt) n1++;
            if (bus0.done) seen = 1'b1;
            if (n1 < 5) tick();
        end
        check("abort_reached_5th", n1, 5);
        set_in(1'b0, 1'b0, 1'b1, 0, 3);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 0, 3);
        check("abort_outs", obs(1'b0), 0);
        check("abort_sent0", sent0_of(1'b0), 0);
        check("abort_sent1", sent1_of(1'b0), 1);
        for (int i = 0; i < 4; i++) begin
            o = obs(1'b0);
            if (o != 4'b0000) seen = 1'b1;
            tick();
        end
        check("abort_quiet_no_done", seen, 0);

        // Reset mid-PULSE1 with Start high in the same cycle.
        set_in(1'b0, 1'b1, 1'b0, 0, 3);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 0, 3);
        repeat (5) tick();
        check("reset_pre_state", obs(1'b0), 4'b1101);
        rst = 1'b1;
        set_in(1'b0, 1'b1, 1'b0, 4, 4);
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 4, 4);
        check("reset_mid_outs", obs(1'b0), 0);
        check("reset_mid_sent0", sent0_of(1'b0), 0);
        check("reset_mid_sent1", sent1_of(1'b0), 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (obs(1'b0) != 4'b0000) seen = 1'b1;
            tick();
        end
        check("reset_no_run", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
